// File: rtl/systolic_result_collector.sv
// Purpose : deskews per-lane systolic results into aligned vectors, buffers them, counts rows per job.
// Latency : last lane sampled at edge E -> FIFO write at E+1 -> out_valid the cycle after (empty FIFO).
// Backpres: out_ready=0 holds the FIFO head stable; a full FIFO with no pop drops the vector and flags proto_err.
// Ports   : clk/rst (async active-low); start; res_valid/res_data skewed lane inputs (lane i at [i*DW +: DW]);
//           out_valid/out_data/out_ready downstream handshake; busy (state != IDLE); done (1-cycle pulse);
//           proto_err (sticky, cleared by reset or an accepted start).
module systolic_result_collector #(
  parameter int N          = 2,
  parameter int DW         = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int M_ROWS     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N-1:0]    res_valid,
  input  logic [N*DW-1:0] res_data,
  output logic            out_valid,
  output logic [N*DW-1:0] out_data,
  input  logic            out_ready,
  output logic            busy,
  output logic            done,
  output logic            proto_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int VW = $clog2(M_ROWS + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic            w_drain_done;

  logic [N-1:0]    r_in_vld;
  logic [N*DW-1:0] r_in_dat;
  logic [N-1:0]    w_av;
  logic [N*DW-1:0] w_ad;

  logic [N*DW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr, r_rd;
  logic [CW-1:0]   r_cnt;
  logic [VW-1:0]   r_vec_cnt;
  logic            r_done, r_perr;

  logic w_pop, w_full, w_row, w_push, w_err, w_row_last, w_start_ok;

  // Input stage: every lane registered every cycle regardless of state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_vld <= '0;
      r_in_dat <= '0;
    end else begin
      r_in_vld <= res_valid;
      r_in_dat <= res_data;
    end
  end

  // Deskew: lane i arrives i cycles after lane 0, so it is delayed by the
  // remaining N-1-i stages to line up with the last lane.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    localparam int D = N - 1 - gi;
    if (D == 0) begin : g_direct
      assign w_av[gi]           = r_in_vld[gi];
      assign w_ad[gi*DW +: DW]  = r_in_dat[gi*DW +: DW];
    end else begin : g_dly
      logic [D-1:0]  r_vsh;
      logic [DW-1:0] r_dsh [D];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_vsh <= '0;
          for (int k = 0; k < D; k++) r_dsh[k] <= '0;
        end else begin
          r_vsh[0] <= r_in_vld[gi];
          r_dsh[0] <= r_in_dat[gi*DW +: DW];
          for (int k = 1; k < D; k++) begin
            r_vsh[k] <= r_vsh[k-1];
            r_dsh[k] <= r_dsh[k-1];
          end
        end
      end
      assign w_av[gi]          = r_vsh[D-1];
      assign w_ad[gi*DW +: DW] = r_dsh[D-1];
    end
  end

  assign out_valid  = (r_cnt != '0);
  assign out_data   = r_mem[r_rd];
  assign w_pop      = out_valid & out_ready;
  assign w_full     = (r_cnt == CW'(FIFO_DEPTH));
  assign w_start_ok = (r_state == S_IDLE) & start;

  // A complete row counts toward the job even if it is dropped on a full
  // FIFO, so a stalled consumer cannot wedge the job open.
  assign w_row      = (&w_av) & (r_state == S_COLLECT);
  assign w_push     = w_row & (~w_full | w_pop);
  assign w_row_last = w_row & (r_vec_cnt == VW'(M_ROWS - 1));
  assign w_err      = ((|w_av) & ~(&w_av))
                    | ((&w_av) & (r_state != S_COLLECT))
                    | (w_row & ~w_push);

  // Aligned-vector FIFO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= w_ad;
        r_wr        <= r_wr + AW'(1);
      end
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_drain_done = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_row_last) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        // Leave on the edge that pops the final entry, not one cycle later.
        if ((r_cnt == '0) || ((r_cnt == CW'(1)) && w_pop)) begin
          w_state_nxt  = S_IDLE;
          w_drain_done = 1'b1;
        end
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vec_cnt <= '0;
      r_done    <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      r_done <= w_drain_done;
      if (w_start_ok)  r_vec_cnt <= '0;
      else if (w_row)  r_vec_cnt <= r_vec_cnt + VW'(1);
      // An error seen in the same cycle as a start is kept.
      if (w_err)           r_perr <= 1'b1;
      else if (w_start_ok) r_perr <= 1'b0;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign proto_err = r_perr;

endmodule

// File: tb/tb_systolic_result_collector.sv
// Bench for systolic_result_collector: directed checks on an M_ROWS=2 instance,
// reference-model checks on an M_ROWS=6 instance (directed then random stimulus).
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_systolic_result_collector;
  localparam int N = 2, DW = 16, DEPTH = 4, M_B = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst, a_start, a_ready, a_ov, a_busy, a_done, a_perr;
  logic [N-1:0]    a_vld;
  logic [N*DW-1:0] a_dat, a_od;
  logic            b_rst, b_start, b_ready, b_ov, b_busy, b_done, b_perr;
  logic [N-1:0]    b_vld;
  logic [N*DW-1:0] b_dat, b_od;

  systolic_result_collector #(.N(N), .DW(DW), .FIFO_DEPTH(DEPTH), .M_ROWS(2)) u_dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .res_valid(a_vld), .res_data(a_dat),
    .out_valid(a_ov), .out_data(a_od), .out_ready(a_ready),
    .busy(a_busy), .done(a_done), .proto_err(a_perr));

  systolic_result_collector #(.N(N), .DW(DW), .FIFO_DEPTH(DEPTH), .M_ROWS(M_B)) u_dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .res_valid(b_vld), .res_data(b_dat),
    .out_valid(b_ov), .out_data(b_od), .out_ready(b_ready),
    .busy(b_busy), .done(b_done), .proto_err(b_perr));

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // ---------------- reference model for instance B ----------------
  // m_hv[k]/m_hd[k] hold the lane samples taken k edges ago (k=0 newest).
  logic [N*DW-1:0] m_q[$];
  int              m_mode;   // 0 idle, 1 collecting, 2 draining
  int              m_cnt;
  bit              m_perr, m_done;
  logic [N-1:0]    m_hv [N];
  logic [DW-1:0]   m_hd [N][N];

  task automatic m_reset();
    m_q.delete();
    m_mode = 0; m_cnt = 0; m_perr = 0; m_done = 0;
    for (int k = 0; k < N; k++) begin
      m_hv[k] = '0;
      for (int i = 0; i < N; i++) m_hd[k][i] = '0;
    end
  endtask

  task automatic m_step();
    logic [N-1:0]    av;
    logic [N*DW-1:0] ad;
    bit pop, row, push, err;
    if (!b_rst) begin
      m_reset();
      return;
    end
    // lane i of a wavefront is sampled i edges after lane 0 and the vector is
    // complete once lane N-1 is in, so lane i's sample is N-1-i edges old.
    for (int i = 0; i < N; i++) begin
      av[i]           = m_hv[N-1-i][i];
      ad[i*DW +: DW]  = m_hd[N-1-i][i];
    end
    pop  = (m_q.size() > 0) && b_ready;
    row  = (&av) && (m_mode == 1);
    push = row && ((m_q.size() < DEPTH) || pop);
    err  = ((|av) && !(&av)) || ((&av) && (m_mode != 1)) || (row && !push);
    m_done = 0;
    if (pop)  void'(m_q.pop_front());
    if (push) m_q.push_back(ad);
    case (m_mode)
      0: if (b_start) begin m_mode = 1; m_cnt = 0; m_perr = 0; end
      1: if (row) begin m_cnt++; if (m_cnt == M_B) m_mode = 2; end
      2: if (m_q.size() == 0) begin m_mode = 0; m_done = 1; end
      default: m_mode = 0;
    endcase
    if (err) m_perr = 1;
    for (int k = N-1; k > 0; k--) begin
      m_hv[k] = m_hv[k-1];
      for (int i = 0; i < N; i++) m_hd[k][i] = m_hd[k-1][i];
    end
    m_hv[0] = b_vld;
    for (int i = 0; i < N; i++) m_hd[0][i] = b_dat[i*DW +: DW];
  endtask

  task automatic b_check();
    check("b_valid", b_ov, m_q.size() > 0);
    if (m_q.size() > 0) check("b_data", b_od, m_q[0]);
    check("b_busy", b_busy, m_mode != 0);
    check("b_done", b_done, m_done);
    check("b_perr", b_perr, m_perr);
  endtask

  task automatic b_cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    b_check();
  endtask

  // ---------------- skewed wavefront generator for B ----------------
  logic [N-1:0]  f_v [N];
  logic [DW-1:0] f_d [N][N];

  task automatic b_drive(input bit launch, input logic [DW-1:0] d0, input bit corrupt);
    int idx;
    if (launch)
      for (int i = 0; i < N; i++) begin
        f_v[i][i] = 1'b1;
        f_d[i][i] = d0 + DW'(i * 16'h1000);
      end
    b_vld = f_v[0];
    for (int i = 0; i < N; i++) b_dat[i*DW +: DW] = f_d[0][i];
    if (corrupt) begin
      idx = $urandom_range(N-1, 0);
      b_vld[idx] = ~b_vld[idx];
    end
    for (int k = 0; k < N-1; k++) begin
      f_v[k] = f_v[k+1];
      for (int i = 0; i < N; i++) f_d[k][i] = f_d[k+1][i];
    end
    f_v[N-1] = '0;
  endtask

  logic [31:0] popq[$];

  task automatic b_drain(input string tag);
    bit seen;
    seen = 0;
    b_ready = 1'b1;
    for (int c = 0; c < 30 && !seen; c++) begin
      if (b_ov) popq.push_back(b_od);
      b_drive(0, '0, 0);
      b_cyc();
      if (b_done) seen = 1;
    end
    check({tag, "_done_seen"}, seen, 1);
  endtask

  // ---------------- directed sequence for A ----------------
  task automatic a_basic(input string t);
    a_ready = 1'b1; a_start = 1'b1; a_vld = '0; a_dat = '0;
    @(negedge clk);                                   // after edge 0
    check({t, "_busy0"}, a_busy, 1);
    a_start = 1'b0; a_vld = 2'b01; a_dat = {16'h0000, 16'h0011};
    @(negedge clk);                                   // after edge 1
    a_vld = 2'b11; a_dat = {16'h0022, 16'h0033};
    @(negedge clk);                                   // after edge 2
    check({t, "_valid2"}, a_ov, 0);
    a_vld = 2'b10; a_dat = {16'h0044, 16'h0000};
    @(negedge clk);                                   // after edge 3
    a_vld = '0; a_dat = '0;
    check({t, "_valid3"}, a_ov, 1);
    check({t, "_data3"}, a_od, 32'h0022_0011);
    @(negedge clk);                                   // after edge 4
    check({t, "_valid4"}, a_ov, 1);
    check({t, "_data4"}, a_od, 32'h0044_0033);
    check({t, "_done4"}, a_done, 0);
    @(negedge clk);                                   // after edge 5
    check({t, "_valid5"}, a_ov, 0);
    check({t, "_done5"}, a_done, 1);
    check({t, "_busy5"}, a_busy, 0);
    check({t, "_perr5"}, a_perr, 0);
    @(negedge clk);
    check({t, "_done6"}, a_done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_start = 0; a_ready = 0; a_vld = '0; a_dat = '0;
    b_start = 0; b_ready = 0; b_vld = '0; b_dat = '0;
    for (int k = 0; k < N; k++) begin
      f_v[k] = '0;
      for (int i = 0; i < N; i++) f_d[k][i] = '0;
    end
    m_reset();
    #1;
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);

    // Reset holds everything idle despite random inputs.
    for (int c = 0; c < 3; c++) begin
      a_start = 1'($urandom); a_ready = 1'($urandom); a_vld = N'($urandom); a_dat = $urandom;
      b_start = 1'($urandom); b_ready = 1'($urandom); b_vld = N'($urandom); b_dat = $urandom;
      b_cyc();
      check("rst_a_valid", a_ov, 0);
      check("rst_a_busy", a_busy, 0);
      check("rst_a_done", a_done, 0);
      check("rst_a_perr", a_perr, 0);
    end
    a_start = 0; a_ready = 0; a_vld = '0; a_dat = '0;
    b_start = 0; b_ready = 0; b_vld = '0; b_dat = '0;
    a_rst = 1'b1;

    // Instance A: basic, reset mid-drain, basic again.
    a_basic("basic");
    a_ready = 1'b0; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_vld = 2'b01; a_dat = {16'h0000, 16'h0055};
    @(negedge clk);
    a_vld = 2'b11; a_dat = {16'h0066, 16'h0077};
    @(negedge clk);
    a_vld = 2'b10; a_dat = {16'h0088, 16'h0000};
    @(negedge clk);
    a_vld = '0; a_dat = '0;
    @(negedge clk);
    check("mid_busy", a_busy, 1);
    check("mid_valid", a_ov, 1);
    check("mid_head", a_od, 32'h0066_0055);
    #2 a_rst = 1'b0;
    #1;
    check("mid_rst_valid", a_ov, 0);
    check("mid_rst_busy", a_busy, 0);
    @(negedge clk);
    a_rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("mid_no_done", a_done, 0);
    end
    a_basic("basic2");

    // Instance B: backpressure with 6 rows into a 4-deep FIFO.
    b_rst = 1'b1;
    b_drive(0, '0, 0); b_cyc();
    b_ready = 1'b0; b_start = 1'b1;
    b_drive(0, '0, 0); b_cyc();
    b_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      b_drive(1, 16'(k * 16'h0101), 0);
      b_cyc();
    end
    for (int c = 0; c < 4; c++) begin
      b_drive(0, '0, 0); b_cyc();
    end
    check("bp_perr", b_perr, 1);
    check("bp_busy", b_busy, 1);
    check("bp_head", b_od, 32'h1101_0101);
    popq.delete();
    b_drain("bp");
    check("bp_pops", popq.size(), 4);
    for (int k = 1; k <= 4 && k <= popq.size(); k++)
      check("bp_pop_data", popq[k-1], {16'(k * 16'h0101 + 16'h1000), 16'(k * 16'h0101)});

    // Full FIFO with a pop in the push cycle.
    b_ready = 1'b0; b_start = 1'b1;
    b_drive(0, '0, 0); b_cyc();
    b_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      b_drive(1, 16'(k * 16'h0202), 0); b_cyc();
    end
    for (int c = 0; c < 3; c++) begin
      b_drive(0, '0, 0); b_cyc();
    end
    b_drive(1, 16'h0a0a, 0); b_cyc();
    b_drive(0, '0, 0); b_cyc();
    b_ready = 1'b1;
    b_drive(0, '0, 0); b_cyc();
    b_ready = 1'b0;
    check("fp_perr", b_perr, 0);
    check("fp_valid", b_ov, 1);
    check("fp_head", b_od, 32'h1404_0404);
    b_drive(1, 16'h0b0b, 0); b_cyc();
    b_drain("fp");
    check("fp_perr_end", b_perr, 0);

    // Skew error: lane 1 alone inside a job.
    b_start = 1'b1;
    b_drive(0, '0, 0); b_cyc();
    b_start = 1'b0;
    b_drive(0, '0, 0); b_vld = 2'b10; b_cyc();
    check("skew_perr_early", b_perr, 0);
    b_drive(0, '0, 0); b_cyc();
    check("skew_perr", b_perr, 1);
    check("skew_valid", b_ov, 0);

    // Random phase against the model.
    for (int c = 0; c < 3000; c++) begin
      b_rst   = ($urandom_range(0, 499) != 0);
      b_start = ($urandom_range(0, 15) == 0);
      b_ready = ($urandom_range(0, 3) != 0);
      b_drive($urandom_range(0, 2) == 0, 16'($urandom), $urandom_range(0, 30) == 0);
      b_cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/systolic_result_collector.md
Name: systolic_result_collector

Overview:
- Drain-side counterpart of the array's load/valid pipeline controller.
- Receives per-lane result valids/data leaving the systolic array with a one-cycle-per-lane skew (lane i lags lane i-1 by 1 cycle) and deskews them into aligned result vectors.
- Buffers the vectors in a small FIFO and presents them downstream with a valid/ready handshake.
- Counts vectors per job and signals completion.

Parameters:
- N, 2, number of result lanes (1..4).
- DW, 16, data width per lane.
- FIFO_DEPTH, 4, aligned-vector FIFO entries (power of 2, >=2).
- M_ROWS, 2, aligned vectors expected per job (>=1).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- start  input  1  begin a job; honoured only in IDLE.
- res_valid  input  N  per-lane result valid from array, skewed.
- res_data  input  N*DW  per-lane result data; lane i at [i*DW +: DW].
- out_valid  output  1  FIFO head valid.
- out_data  output  N*DW  FIFO head vector, same lane packing.
- out_ready  input  1  downstream accept; pop when out_valid & out_ready.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse at job completion.
- proto_err  output  1  sticky protocol error flag, cleared by reset or by an accepted start.

Behaviour:
- Reset (rst=0, async): state=IDLE; delay lines, FIFO pointers/count, vec_count cleared. Outputs out_valid=0, out_data=0, busy=0, done=0, proto_err=0.
- Input stage: res_valid/res_data registered every cycle in every state.
- Deskew: registered lane i passes through N-1-i further delay stages (lane N-1 has none). This yields aligned valid vector av[N-1:0] and aligned data.
- Wavefront: lane 0 sampled at edge E, lane i at E+i. It forms an aligned vector in the cycle after edge E+N-1.
- Push rules (evaluated in the aligned cycle):
  - av all ones and state==COLLECT: write vector into FIFO at the next edge; vec_count+1.
  - av all ones and state!=COLLECT: discard; proto_err<=1.
  - av nonzero but not all ones (missing/extra lane): discard; proto_err<=1.
  - FIFO full with no pop the same cycle: discard; proto_err<=1; vec_count still +1, so the job still terminates.
  - FIFO full with a pop the same cycle: push accepted.
- Latency, N=2: lane1 sampled at edge E → FIFO write at E+1 → out_valid=1 in cycle after E+1 (empty FIFO, no backpressure).
- FIFO: registered head; out_data holds stable while out_valid=1 & out_ready=0. Simultaneous push+pop keeps count. Pointers wrap modulo FIFO_DEPTH. out_data=0 when empty is not required; only out_valid is checked.
- FSM:
  - IDLE: start=1 → COLLECT; vec_count<=0; proto_err<=0.
  - COLLECT: push/discard that makes vec_count==M_ROWS → DRAIN at that edge.
  - DRAIN: FIFO empty (including after the final pop edge) → IDLE; done=1 for exactly the first cycle in IDLE.
  - start while busy: ignored, no flag.
- busy is registered state decode: 1 from the cycle after the accepted start through the last DRAIN cycle.
- Reset mid-operation: all buffered vectors lost; no done pulse.

Test Plan:
- Reset → with rst=0 for 3 cycles and random inputs: out_valid=0, busy=0, done=0, proto_err=0.
- Basic (N=2, M_ROWS=2, out_ready=1):
  - Stimulus: start at edge 0. Lane0=0x0011 at edge 1, lane1=0x0022 with lane0=0x0033 at edge 2, lane1=0x0044 at edge 3.
  - Response: out_data=0x00220011 valid after edge 3; 0x00440033 after edge 4; done pulse after edge 5; busy=0 then.
- Backpressure (FIFO_DEPTH=4, M_ROWS=6, out_ready=0):
  - Stimulus: 6 back-to-back wavefronts 0x0101..0x0606 (lane1=lane0+0x1000).
  - Response: first 4 held with out_data stable; 5th and 6th dropped with proto_err=1; state goes to DRAIN.
  - Then out_ready=1: exactly 4 pops in order, then done.
- Skew error: lane1 valid with no lane0 one cycle earlier → proto_err=1 in the cycle after alignment; no push; vec_count unchanged.
- Full + simultaneous pop: FIFO at 4 entries, out_ready=1 on the push cycle → push accepted, count stays 4, proto_err stays 0.
- Reset mid-DRAIN with 2 entries queued → out_valid=0 immediately (async); busy=0; no done. A new start then behaves as in the basic test.
